// File: rtl/ccu_snoop_path_arbiter.sv
// N-path snoop arbiter: round-robin merge of AC requests onto one fabric port, same-line
// blocking against an ordered outstanding table, in-order CR return. Optional counters: CCU_SNOOP_PERF_EN.
module ccu_snoop_path_arbiter #(
  parameter int NumPaths     = 2,
  parameter int AddrWidth    = 64,
  parameter int LineWidth    = 512,
  parameter int MaxTrans     = 4,
  parameter int AcSnoopWidth = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumPaths-1:0]                  path_ac_valid_i,
  output logic [NumPaths-1:0]                  path_ac_ready_o,
  input  logic [NumPaths-1:0][AddrWidth-1:0]   path_ac_addr_i,
  input  logic [NumPaths-1:0][AcSnoopWidth-1:0] path_ac_snoop_i,
  output logic [NumPaths-1:0]                  path_cr_valid_o,
  input  logic [NumPaths-1:0]                  path_cr_ready_i,
  output logic [4:0]                           path_cr_resp_o,
  output logic                                 snp_ac_valid_o,
  input  logic                                 snp_ac_ready_i,
  output logic [AddrWidth-1:0]                 snp_ac_addr_o,
  output logic [AcSnoopWidth-1:0]              snp_ac_snoop_o,
  input  logic                                 snp_cr_valid_i,
  output logic                                 snp_cr_ready_o,
  input  logic [4:0]                           snp_cr_resp_i,
  output logic                                 cr_unexpected_o,
  output logic [31:0]                          stall_cycles_o,
  output logic [31:0]                          snoops_issued_o
);

  localparam int OffW  = $clog2(LineWidth / 8);
  localparam int LineW = AddrWidth - OffW;
  localparam int IdxW  = (NumPaths > 1) ? $clog2(NumPaths) : 1;
  localparam int PtrW  = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int CntW  = $clog2(MaxTrans + 1);

  typedef enum logic [0:0] {AC_EMPTY = 1'b0, AC_FULL = 1'b1} ac_state_e;

  function automatic logic [LineW-1:0] line_of(input logic [AddrWidth-1:0] addr);
    return LineW'(addr >> OffW);
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(MaxTrans - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  logic [LineW-1:0]                   tbl_line_r [MaxTrans];
  logic [IdxW-1:0]                    tbl_path_r [MaxTrans];
  logic [MaxTrans-1:0]                tbl_vld_r;
  logic [PtrW-1:0]                    head_r, tail_r;
  logic [CntW-1:0]                    count_r;
  logic [IdxW-1:0]                    rr_r;
  ac_state_e                          ac_state_r, ac_state_s;
  logic [AddrWidth-1:0]               ac_addr_r;
  logic [AcSnoopWidth-1:0]            ac_snoop_r;
  logic [NumPaths-1:0][MaxTrans-1:0]  hit_s;
  logic [NumPaths-1:0]                elig_s;
  logic [IdxW-1:0]                    grant_idx_s;
  logic                               grant_vld_s, accept_s, pop_s, tbl_nempty_s, buf_free_s;
  logic [IdxW-1:0]                    head_path_s;

  // Line-address conflict of each requesting path against every live table entry
  always_comb begin
    for (int i = 0; i < NumPaths; i++) begin
      for (int e = 0; e < MaxTrans; e++) begin
        hit_s[i][e] = tbl_vld_r[e] & (tbl_line_r[e] == line_of(path_ac_addr_i[i]));
      end
      elig_s[i] = path_ac_valid_i[i] & ~(|hit_s[i]);
    end
  end

  // Round-robin pick among eligible paths, starting after the last winner
  always_comb begin
    int j;
    grant_vld_s = 1'b0;
    grant_idx_s = rr_r;
    for (int k = 1; k <= NumPaths; k++) begin
      j = (int'(rr_r) + k) % NumPaths;
      if (!grant_vld_s && elig_s[j]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = IdxW'(j);
      end else begin
        grant_idx_s = grant_idx_s;
      end
    end
  end

  assign buf_free_s   = (ac_state_r == AC_EMPTY) | snp_ac_ready_i;
  assign accept_s     = grant_vld_s & (count_r < CntW'(MaxTrans)) & buf_free_s;
  assign tbl_nempty_s = (count_r != '0);
  assign head_path_s  = tbl_path_r[head_r];

  // Per-path handshake fan-out for AC ready and CR valid
  always_comb begin
    for (int i = 0; i < NumPaths; i++) begin
      path_ac_ready_o[i] = accept_s & (grant_idx_s == IdxW'(i));
      path_cr_valid_o[i] = snp_cr_valid_i & tbl_nempty_s & (head_path_s == IdxW'(i));
    end
  end

  assign snp_cr_ready_o  = tbl_nempty_s & path_cr_ready_i[head_path_s];
  assign pop_s           = snp_cr_valid_i & snp_cr_ready_o;
  assign path_cr_resp_o  = snp_cr_resp_i;
  assign cr_unexpected_o = snp_cr_valid_i & ~tbl_nempty_s;

  // AC buffer next state; reload on ready+accept avoids a bubble
  always_comb begin
    ac_state_s = ac_state_r;
    case (ac_state_r)
      AC_EMPTY: ac_state_s = accept_s ? AC_FULL : AC_EMPTY;
      AC_FULL: begin
        if (accept_s)            ac_state_s = AC_FULL;
        else if (snp_ac_ready_i) ac_state_s = AC_EMPTY;
        else                     ac_state_s = AC_FULL;
      end
      default: ac_state_s = AC_EMPTY;
    endcase
  end

  // AC buffer state and payload registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ac_state_r <= AC_EMPTY;
      ac_addr_r  <= '0;
      ac_snoop_r <= '0;
    end else begin
      ac_state_r <= ac_state_s;
      if (accept_s) begin
        ac_addr_r  <= path_ac_addr_i[grant_idx_s];
        ac_snoop_r <= path_ac_snoop_i[grant_idx_s];
      end
    end
  end

  assign snp_ac_valid_o = (ac_state_r == AC_FULL);
  assign snp_ac_addr_o  = ac_addr_r;
  assign snp_ac_snoop_o = ac_snoop_r;

  // Outstanding table: push at tail on accept, pop at head on CR handshake
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_r    <= '0;
      tail_r    <= '0;
      count_r   <= '0;
      tbl_vld_r <= '0;
      rr_r      <= IdxW'(NumPaths - 1);
      for (int e = 0; e < MaxTrans; e++) begin
        tbl_line_r[e] <= '0;
        tbl_path_r[e] <= '0;
      end
    end else begin
      if (pop_s) begin
        tbl_vld_r[head_r] <= 1'b0;
        head_r            <= ptr_inc(head_r);
      end
      if (accept_s) begin
        tbl_line_r[tail_r] <= line_of(path_ac_addr_i[grant_idx_s]);
        tbl_path_r[tail_r] <= grant_idx_s;
        tbl_vld_r[tail_r]  <= 1'b1;
        tail_r             <= ptr_inc(tail_r);
        rr_r               <= grant_idx_s;
      end
      count_r <= count_r + CntW'(accept_s) - CntW'(pop_s);
    end
  end

`ifdef CCU_SNOOP_PERF_EN
  logic [31:0] stall_cnt_r, issued_cnt_r;

  // Saturating stall and issue counters
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_r  <= 32'd0;
      issued_cnt_r <= 32'd0;
    end else begin
      if ((|path_ac_valid_i) && !accept_s && (stall_cnt_r != 32'hFFFF_FFFF))
        stall_cnt_r <= stall_cnt_r + 32'd1;
      if (accept_s && (issued_cnt_r != 32'hFFFF_FFFF))
        issued_cnt_r <= issued_cnt_r + 32'd1;
    end
  end

  assign stall_cycles_o  = stall_cnt_r;
  assign snoops_issued_o = issued_cnt_r;
`else
  assign stall_cycles_o  = 32'd0;
  assign snoops_issued_o = 32'd0;
`endif

endmodule

// File: tb/tb_ccu_snoop_path_arbiter.sv
// Bench for ccu_snoop_path_arbiter: directed vector table, corner sequences and random
// traffic against a queue-based reference model.
module tb_ccu_snoop_path_arbiter;
  localparam int NP = 2;
  localparam int AW = 64;
  localparam int MT = 4;
  localparam int SW = 4;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                   rst_ni;
  logic [NP-1:0]          path_ac_valid_i, path_ac_ready_o, path_cr_valid_o, path_cr_ready_i;
  logic [NP-1:0][AW-1:0]  path_ac_addr_i;
  logic [NP-1:0][SW-1:0]  path_ac_snoop_i;
  logic [4:0]             path_cr_resp_o, snp_cr_resp_i;
  logic                   snp_ac_valid_o, snp_ac_ready_i, snp_cr_valid_i, snp_cr_ready_o, cr_unexpected_o;
  logic [AW-1:0]          snp_ac_addr_o;
  logic [SW-1:0]          snp_ac_snoop_o;
  logic [31:0]            stall_cycles_o, snoops_issued_o;

  ccu_snoop_path_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .path_ac_valid_i(path_ac_valid_i), .path_ac_ready_o(path_ac_ready_o),
    .path_ac_addr_i(path_ac_addr_i), .path_ac_snoop_i(path_ac_snoop_i),
    .path_cr_valid_o(path_cr_valid_o), .path_cr_ready_i(path_cr_ready_i),
    .path_cr_resp_o(path_cr_resp_o),
    .snp_ac_valid_o(snp_ac_valid_o), .snp_ac_ready_i(snp_ac_ready_i),
    .snp_ac_addr_o(snp_ac_addr_o), .snp_ac_snoop_o(snp_ac_snoop_o),
    .snp_cr_valid_i(snp_cr_valid_i), .snp_cr_ready_o(snp_cr_ready_o),
    .snp_cr_resp_i(snp_cr_resp_i), .cr_unexpected_o(cr_unexpected_o),
    .stall_cycles_o(stall_cycles_o), .snoops_issued_o(snoops_issued_o)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding snoops as an ordered queue of {line, path}
  typedef struct {logic [57:0] line; int path;} ent_t;
  ent_t        mq[$];
  bit          m_bv;
  logic [63:0] m_ba;
  logic [3:0]  m_bs;
  int          m_rr;
  logic [31:0] m_stall, m_issued;

  function automatic logic [57:0] line_of(input logic [63:0] a);
    return a[63:6];
  endfunction

  function automatic bit in_q(input logic [57:0] l);
    foreach (mq[k]) if (mq[k].line == l) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_bv = 1'b0; m_ba = '0; m_bs = '0; m_rr = NP - 1;
    m_stall = '0; m_issued = '0;
  endtask

  // One clock cycle: drive, check every output against the model, then advance the model
  task automatic step(input logic rst, input logic [1:0] acv, input logic [63:0] a0, input logic [63:0] a1,
                      input logic [3:0] s0, input logic [3:0] s1, input logic acr, input logic crv,
                      input logic [1:0] crr, input logic [4:0] resp);
    logic [63:0] a [NP];
    logic [3:0]  s [NP];
    int          g, h;
    bit          acc;
    logic [1:0]  e_rdy, e_crv;
    logic        e_crr, e_unx;
    ent_t        ne;
    a[0] = a0; a[1] = a1; s[0] = s0; s[1] = s1;
    @(posedge clk_i); #1;
    rst_ni = rst; path_ac_valid_i = acv; path_ac_addr_i[0] = a0; path_ac_addr_i[1] = a1;
    path_ac_snoop_i[0] = s0; path_ac_snoop_i[1] = s1; snp_ac_ready_i = acr;
    snp_cr_valid_i = crv; path_cr_ready_i = crr; snp_cr_resp_i = resp;
    #4;
    g = -1;
    for (int k = 1; k <= NP; k++) begin
      int j;
      j = (m_rr + k) % NP;
      if (g < 0 && acv[j] && !in_q(line_of(a[j]))) g = j;
    end
    acc = (g >= 0) && (mq.size() < MT) && (!m_bv || acr);
    e_rdy = '0; e_crv = '0; e_crr = 1'b0; e_unx = 1'b0;
    if (acc) e_rdy[g] = 1'b1;
    if (mq.size() > 0) begin
      h = mq[0].path;
      e_crv[h] = crv;
      e_crr = crr[h];
    end else begin
      e_unx = crv;
    end
    check("ac_ready", path_ac_ready_o, e_rdy);
    check("snp_ac_valid", snp_ac_valid_o, m_bv);
    check("snp_ac_addr", snp_ac_addr_o, m_ba);
    check("snp_ac_snoop", snp_ac_snoop_o, m_bs);
    check("cr_valid", path_cr_valid_o, e_crv);
    check("snp_cr_ready", snp_cr_ready_o, e_crr);
    check("cr_resp", path_cr_resp_o, resp);
    check("cr_unexpected", cr_unexpected_o, e_unx);
`ifdef CCU_SNOOP_PERF_EN
    check("stall_cycles", stall_cycles_o, m_stall);
    check("snoops_issued", snoops_issued_o, m_issued);
`else
    check("stall_cycles", stall_cycles_o, 32'd0);
    check("snoops_issued", snoops_issued_o, 32'd0);
`endif
    if (!rst) begin
      model_reset();
    end else begin
      if (crv && e_crr) void'(mq.pop_front());
      if (acc) begin
        ne.line = line_of(a[g]); ne.path = g;
        mq.push_back(ne);
        m_rr = g;
        m_ba = a[g]; m_bs = s[g]; m_bv = 1'b1;
      end else if (acr) begin
        m_bv = 1'b0;
      end
      if ((|acv) && !acc && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (acc && m_issued != 32'hFFFF_FFFF) m_issued++;
    end
  endtask

  task automatic idle(input logic rst);
    step(rst, 2'b00, 64'h0, 64'h0, 4'h0, 4'h0, 1'b1, 1'b0, 2'b11, 5'h0);
  endtask

  typedef struct {
    logic [1:0]  acv;
    logic [63:0] a0, a1;
    logic        acr, crv;
    logic [1:0]  crr;
    logic [4:0]  resp;
    logic [1:0]  e_rdy;
    logic        e_snpv;
    logic [1:0]  e_crv;
    logic        e_crr, e_unx;
  } vec_t;

  vec_t tv[13];

  initial begin
    //              acv    a0          a1          acr   crv   crr    resp  | rdy   snpv  crv    crr   unx
    tv[0]  = '{2'b00, 64'h1000, 64'h2000, 1'b1, 1'b1, 2'b11, 5'h00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1};
    tv[1]  = '{2'b01, 64'h1000, 64'h2000, 1'b0, 1'b0, 2'b11, 5'h00, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0};
    tv[2]  = '{2'b00, 64'h1000, 64'h2000, 1'b1, 1'b0, 2'b11, 5'h00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0};
    tv[3]  = '{2'b00, 64'h1000, 64'h2000, 1'b1, 1'b1, 2'b11, 5'h01, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0};
    tv[4]  = '{2'b11, 64'h1000, 64'h2000, 1'b1, 1'b0, 2'b11, 5'h00, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0};
    tv[5]  = '{2'b11, 64'h1000, 64'h2000, 1'b1, 1'b0, 2'b11, 5'h00, 2'b01, 1'b1, 2'b00, 1'b1, 1'b0};
    tv[6]  = '{2'b11, 64'h1000, 64'h2000, 1'b1, 1'b1, 2'b11, 5'h03, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0};
    tv[7]  = '{2'b11, 64'h1000, 64'h2000, 1'b1, 1'b1, 2'b01, 5'h04, 2'b10, 1'b0, 2'b01, 1'b1, 1'b0};
    tv[8]  = '{2'b01, 64'h1000, 64'h2000, 1'b1, 1'b0, 2'b11, 5'h00, 2'b01, 1'b1, 2'b00, 1'b1, 1'b0};
    tv[9]  = '{2'b10, 64'h1000, 64'h1020, 1'b1, 1'b1, 2'b00, 5'h05, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0};
    tv[10] = '{2'b10, 64'h1000, 64'h1020, 1'b1, 1'b1, 2'b10, 5'h06, 2'b00, 1'b0, 2'b10, 1'b1, 1'b0};
    tv[11] = '{2'b10, 64'h1000, 64'h1020, 1'b1, 1'b1, 2'b01, 5'h07, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0};
    tv[12] = '{2'b10, 64'h1000, 64'h1020, 1'b1, 1'b0, 2'b01, 5'h00, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0};

    rst_ni = 1'b0; path_ac_valid_i = '0; path_ac_addr_i = '0; path_ac_snoop_i = '0;
    snp_ac_ready_i = 1'b0; snp_cr_valid_i = 1'b0; path_cr_ready_i = '0; snp_cr_resp_i = '0;
    repeat (2) @(posedge clk_i);
    model_reset();

    // Directed vector table starting from reset state
    for (int i = 0; i < 13; i++) begin
      step(1'b1, tv[i].acv, tv[i].a0, tv[i].a1, 4'h1, 4'h2, tv[i].acr, tv[i].crv, tv[i].crr, tv[i].resp);
      check($sformatf("vec%0d_ac_ready", i), path_ac_ready_o, tv[i].e_rdy);
      check($sformatf("vec%0d_snp_valid", i), snp_ac_valid_o, tv[i].e_snpv);
      check($sformatf("vec%0d_cr_valid", i), path_cr_valid_o, tv[i].e_crv);
      check($sformatf("vec%0d_cr_ready", i), snp_cr_ready_o, tv[i].e_crr);
      check($sformatf("vec%0d_unexpected", i), cr_unexpected_o, tv[i].e_unx);
    end

    // Table full: four accepts, stall while full, one CR frees exactly one slot next cycle
    idle(1'b0); idle(1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'b01, 64'h4000 + 64'(i) * 64'h40, 64'h0, 4'h3, 4'h0, 1'b1, 1'b0, 2'b11, 5'h0);
      check("full_ready", path_ac_ready_o, (i < 4) ? 2'b01 : 2'b00);
    end
    step(1'b1, 2'b01, 64'h5000, 64'h0, 4'h3, 4'h0, 1'b1, 1'b1, 2'b11, 5'h2);
    check("full_pop_same_cycle", path_ac_ready_o, 2'b00);
    step(1'b1, 2'b01, 64'h5000, 64'h0, 4'h3, 4'h0, 1'b1, 1'b0, 2'b11, 5'h0);
    check("full_after_pop", path_ac_ready_o, 2'b01);

    // Fabric backpressure: payload holds, no further accepts until ready
    idle(1'b0); idle(1'b1);
    step(1'b1, 2'b11, 64'h8000, 64'h9000, 4'h5, 4'h6, 1'b0, 1'b0, 2'b11, 5'h0);
    check("bp_first_accept", path_ac_ready_o, 2'b01);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 2'b11, 64'h8000, 64'h9000, 4'h5, 4'h6, 1'b0, 1'b0, 2'b11, 5'h0);
      check("bp_ready_low", path_ac_ready_o, 2'b00);
      check("bp_payload", snp_ac_addr_o, 64'h8000);
    end
    step(1'b1, 2'b11, 64'h8000, 64'h9000, 4'h5, 4'h6, 1'b1, 1'b0, 2'b11, 5'h0);
    check("bp_release", path_ac_ready_o, 2'b10);
    step(1'b1, 2'b01, 64'hA000, 64'h9000, 4'h5, 4'h6, 1'b1, 1'b0, 2'b11, 5'h0);

    // Reset with three outstanding entries
    idle(1'b0);
    step(1'b1, 2'b00, 64'h0, 64'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'b11, 5'h0);
    check("rst_snp_valid", snp_ac_valid_o, 1'b0);
    check("rst_cr_ready", snp_cr_ready_o, 1'b0);
    check("rst_unexpected", cr_unexpected_o, 1'b1);

    // Random traffic over a small line pool to force conflicts
    for (int c = 0; c < 3000; c++) begin
      logic [63:0] ra0, ra1;
      ra0 = 64'h10000 + (64'($urandom_range(0, 5)) << 6) + 64'($urandom_range(0, 63));
      ra1 = 64'h10000 + (64'($urandom_range(0, 5)) << 6) + 64'($urandom_range(0, 63));
      step(($urandom_range(0, 499) != 0), 2'($urandom), ra0, ra1, 4'($urandom), 4'($urandom),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4),
           2'($urandom), 5'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
